// File: rtl/intersection_sequencer.sv
// Phase controller for the TH / Norton signal heads and pedestrian walk lamps.
// Optional walk countdown output is enabled by defining PED_COUNTDOWN_EN.
module intersection_sequencer #(
    parameter int TICKS_PER_MS = 10,
    parameter int GREEN_TH_MS  = 20000,
    parameter int GREEN_N_MS   = 20000,
    parameter int MIN_GREEN_MS = 5000,
    parameter int YELLOW_MS    = 3000,
    parameter int ALLRED_MS    = 1000,
    parameter int WALK_MS      = 10000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       sensor_th,
    input  logic       sensor_nn,
    input  logic       sensor_ns,
    input  logic       ped_th,
    input  logic       ped_n,
    output logic       set_th,
    output logic       set_nn,
    output logic       set_ns,
    output logic       chg_th,
    output logic       chg_nn,
    output logic       chg_ns,
    output logic       walk_th,
    output logic       walk_n,
    output logic [2:0] phase,
    output logic       ped_pending
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [7:0] walk_remaining_s
`endif
);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        TH_GREEN  = 3'd1,
        TH_YELLOW = 3'd2,
        ALLRED_A  = 3'd3,
        N_GREEN   = 3'd4,
        N_YELLOW  = 3'd5,
        ALLRED_B  = 3'd6,
        PED_WALK  = 3'd7
    } state_t;

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    state_t        r_state;
    logic [PW-1:0] r_prescale;
    logic [17:0]   r_phaseMs;
    logic          r_started;
    logic [4:0]    r_sync1;
    logic [4:0]    r_sync2;
    logic [1:0]    r_pedPrev;
    logic          r_pedPending;
    logic          r_setAll;
    logic          r_chgTh;
    logic          r_chgN;
    logic          r_walk;

    logic          w_tick;
    logic [17:0]   w_limit;
    logic          w_timeUp;
    logic          w_gapTh;
    logic          w_gapN;
    logic          w_exit;
    state_t        w_next;
    logic          w_pedRise;
    logic          w_sTh;
    logic          w_sN;

    // Synchronized inputs: bit 0 TH, 1 NN, 2 NS, 3 ped TH, 4 ped Norton.
    assign w_sTh     = r_sync2[0];
    assign w_sN      = r_sync2[1] | r_sync2[2];
    assign w_pedRise = |(r_sync2[4:3] & ~r_pedPrev);
    assign w_tick    = (r_prescale == PW'(TICKS_PER_MS - 1));

    always_comb begin
        w_limit = 18'(ALLRED_MS);
        w_next  = r_state;
        w_exit  = 1'b0;
        case (r_state)
            TH_GREEN:             w_limit = 18'(GREEN_TH_MS);
            N_GREEN:              w_limit = 18'(GREEN_N_MS);
            TH_YELLOW, N_YELLOW:  w_limit = 18'(YELLOW_MS);
            PED_WALK:             w_limit = 18'(WALK_MS);
            default:              w_limit = 18'(ALLRED_MS);
        endcase
        w_timeUp = w_tick && (r_phaseMs == w_limit - 18'd1);
        w_gapTh  = w_tick && (r_phaseMs >= 18'(MIN_GREEN_MS - 1)) && !w_sTh && w_sN;
        w_gapN   = w_tick && (r_phaseMs >= 18'(MIN_GREEN_MS - 1)) && !w_sN && w_sTh;
        // INIT waits for the start-up set pulse so set and chg never coincide.
        case (r_state)
            INIT:      begin w_exit = r_started && w_timeUp; w_next = TH_GREEN;  end
            TH_GREEN:  begin w_exit = w_timeUp || w_gapTh;   w_next = TH_YELLOW; end
            TH_YELLOW: begin w_exit = w_timeUp;              w_next = ALLRED_A;  end
            ALLRED_A:  begin w_exit = w_timeUp;              w_next = N_GREEN;   end
            N_GREEN:   begin w_exit = w_timeUp || w_gapN;    w_next = N_YELLOW;  end
            N_YELLOW:  begin w_exit = w_timeUp;              w_next = ALLRED_B;  end
            ALLRED_B:  begin
                w_exit = w_timeUp;
                w_next = r_pedPending ? PED_WALK : TH_GREEN;
            end
            PED_WALK:  begin w_exit = w_timeUp;              w_next = TH_GREEN;  end
            default:   begin w_exit = 1'b0;                  w_next = INIT;      end
        endcase
    end

`ifdef PED_COUNTDOWN_EN
    localparam int WALK_S_RAW = (WALK_MS + 999) / 1000;
    localparam int WALK_S     = (WALK_S_RAW > 255) ? 255 : WALK_S_RAW;
    localparam int WALK_SUB0  = (WALK_MS - 1) % 1000;
    logic [7:0] r_walkSec;
    logic [9:0] r_walkSub;
    assign walk_remaining_s = r_walkSec;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= INIT;
            r_prescale   <= '0;
            r_phaseMs    <= '0;
            r_started    <= 1'b0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_pedPrev    <= '0;
            r_pedPending <= 1'b0;
            r_setAll     <= 1'b0;
            r_chgTh      <= 1'b0;
            r_chgN       <= 1'b0;
            r_walk       <= 1'b0;
`ifdef PED_COUNTDOWN_EN
            r_walkSec    <= '0;
            r_walkSub    <= '0;
`endif
        end else begin
            r_sync1   <= {ped_n, ped_th, sensor_ns, sensor_nn, sensor_th};
            r_sync2   <= r_sync1;
            r_pedPrev <= r_sync2[4:3];
            r_started <= 1'b1;
            r_setAll  <= !r_started;
            r_chgTh   <= w_exit && (w_next == TH_GREEN || r_state == TH_GREEN
                                    || r_state == TH_YELLOW);
            r_chgN    <= w_exit && (r_state == ALLRED_A || r_state == N_GREEN
                                    || r_state == N_YELLOW);
            r_pedPending <= ((w_exit && w_next == PED_WALK) ? 1'b0 : r_pedPending)
                            | w_pedRise;

            if (w_exit) begin
                r_state    <= w_next;
                r_prescale <= '0;
                r_phaseMs  <= '0;
                r_walk     <= (w_next == PED_WALK);
            end else begin
                r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
                if (w_tick)
                    r_phaseMs <= r_phaseMs + 18'd1;
            end

`ifdef PED_COUNTDOWN_EN
            // Seconds drop each time the remaining ms crosses a 1000 boundary.
            if (w_exit && w_next == PED_WALK) begin
                r_walkSec <= 8'(WALK_S);
                r_walkSub <= 10'(WALK_SUB0);
            end else if (w_exit) begin
                r_walkSec <= '0;
                r_walkSub <= '0;
            end else if (r_state == PED_WALK && w_tick) begin
                if (r_walkSub == 10'd0) begin
                    if (r_walkSec != 8'd0)
                        r_walkSec <= r_walkSec - 8'd1;
                    r_walkSub <= 10'd999;
                end else begin
                    r_walkSub <= r_walkSub - 10'd1;
                end
            end
`endif
        end
    end

    assign set_th      = r_setAll;
    assign set_nn      = r_setAll;
    assign set_ns      = r_setAll;
    assign chg_th      = r_chgTh;
    assign chg_nn      = r_chgN;
    assign chg_ns      = r_chgN;
    assign walk_th     = r_walk;
    assign walk_n      = r_walk;
    assign phase       = r_state;
    assign ped_pending = r_pedPending;

endmodule
